// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes the opcode into a 13-bit control word and carries
// {valid, cw, rd} through STAGES registers. Load-use detection is built only with CTRL_HAZARD_EN.
module ctrl_pipe #(
    parameter int STAGES = 3,
    parameter int REG_W  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             ext_stall,
    input  logic             flush,
    output logic             x_valid,
    output logic [12:0]      x_cw,
    output logic [REG_W-1:0] x_rd,
    output logic             w_valid,
    output logic [12:0]      w_cw,
    output logic [REG_W-1:0] w_rd,
    output logic             hazard_stall
);

    localparam int CW_RWE     = 0;
    localparam int CW_DMWE    = 1;
    localparam int CW_RWD     = 2;
    localparam int CW_RDST    = 3;
    localparam int CW_ALUINB  = 4;
    localparam int CW_BNE     = 5;
    localparam int CW_BLT     = 6;
    localparam int CW_JUMP    = 7;
    localparam int CW_JR      = 8;
    localparam int CW_JAL     = 9;
    localparam int CW_SETX    = 10;
    localparam int CW_BEX     = 11;
    localparam int CW_ILLEGAL = 12;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    logic             st_v  [1:STAGES];
    logic [12:0]      st_cw [1:STAGES];
    logic [REG_W-1:0] st_rd [1:STAGES];

    logic [12:0] cw_dec;
    logic        accept;

    always_comb begin
        cw_dec = '0;
        case (opcode)
            OP_R:    begin cw_dec[CW_RWE] = 1'b1; cw_dec[CW_RDST] = 1'b1; end
            OP_J:    cw_dec[CW_JUMP] = 1'b1;
            OP_BNE:  cw_dec[CW_BNE] = 1'b1;
            OP_JAL:  begin cw_dec[CW_RWE] = 1'b1; cw_dec[CW_JUMP] = 1'b1; cw_dec[CW_JAL] = 1'b1; end
            OP_JR:   cw_dec[CW_JR] = 1'b1;
            OP_ADDI: begin cw_dec[CW_RWE] = 1'b1; cw_dec[CW_ALUINB] = 1'b1; end
            OP_BLT:  cw_dec[CW_BLT] = 1'b1;
            OP_SW:   begin cw_dec[CW_DMWE] = 1'b1; cw_dec[CW_ALUINB] = 1'b1; end
            OP_LW:   begin cw_dec[CW_RWE] = 1'b1; cw_dec[CW_RWD] = 1'b1; cw_dec[CW_ALUINB] = 1'b1; end
            OP_SETX: begin cw_dec[CW_RWE] = 1'b1; cw_dec[CW_SETX] = 1'b1; end
            OP_BEX:  cw_dec[CW_BEX] = 1'b1;
            default: cw_dec[CW_ILLEGAL] = 1'b1;
        endcase
    end

`ifdef CTRL_HAZARD_EN
    // A load in stage 1 whose destination feeds the decode instruction; r0 never creates a dependency.
    assign hazard_stall = in_valid & st_v[1] & st_cw[1][CW_RWD] & ~flush
                        & (st_rd[1] != '0) & ((st_rd[1] == rs) | (st_rd[1] == rt));
`else
    logic unused_hz_fields;
    assign unused_hz_fields = ^{rs, rt};
    assign hazard_stall     = 1'b0;
`endif

    assign in_ready = ~ext_stall & ~hazard_stall;
    assign accept   = in_valid & in_ready & ~flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 1; k <= STAGES; k++) begin
                st_v[k]  <= 1'b0;
                st_cw[k] <= '0;
                st_rd[k] <= '0;
            end
        end else if (ext_stall) begin
            if (flush) begin
                st_v[1]  <= 1'b0;
                st_cw[1] <= '0;
            end
        end else begin
            for (int k = 2; k <= STAGES; k++) begin
                st_v[k]  <= st_v[k-1];
                st_cw[k] <= st_cw[k-1];
                st_rd[k] <= st_rd[k-1];
            end
            // The killed stage-1 instruction moves on as a bubble so its effects never reach W.
            if (flush) begin
                st_v[2]  <= 1'b0;
                st_cw[2] <= '0;
            end
            st_v[1]  <= accept;
            st_cw[1] <= accept ? cw_dec : '0;
            st_rd[1] <= accept ? rd : '0;
        end
    end

    assign x_valid = st_v[1];
    assign x_cw    = st_cw[1];
    assign x_rd    = st_rd[1];
    assign w_valid = st_v[STAGES];
    assign w_cw    = st_cw[STAGES];
    assign w_rd    = st_rd[STAGES];

endmodule
